// File: rtl/gpf_prog_loader.sv
// Serial program loader: oversamples a 3-wire link on Clk and writes framed
// instruction words into the FSM instruction store with auto-incrementing address.
module gpf_prog_loader #(
  parameter int IW = 24,
  parameter int AW = 4,
  parameter int HW = 8
) (
  input  logic          Clk,
  input  logic          nRst,
  input  logic          SPIck_ai,
  input  logic          SPIdat_ai,
  input  logic          SPIcs_n_ai,
  output logic          WrEn_o,
  output logic [AW-1:0] WrAddr_o,
  output logic [IW-1:0] WrData_o,
  output logic          Busy_o,
  output logic          Done_o,
  output logic          Err_o
);

  localparam int SW = (IW > HW) ? IW : HW;
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] HDR_BITS  = CW'(HW);
  localparam logic [CW-1:0] WORD_BITS = CW'(IW);

  typedef enum logic [1:0] {IDLE, HDR, DATA, IGNORE} state_t;

  state_t        state, state_nxt;
  logic          ck_p0, ck_p1, ck_p2;
  logic          dat_p0, dat_p1;
  logic          cs_p0, cs_p1, cs_p2;
  logic          ck_rise, cs_fall;

  logic [SW-1:0] shreg, shreg_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic          wrote, wrote_nxt;
  logic          err_nxt, done_nxt, wr_en_nxt;
  logic [AW-1:0] wr_addr_nxt;
  logic [IW-1:0] wr_data_nxt;

  // Stage p0/p1: two-flop synchronizers; p2 holds previous value for edge detection
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      ck_p0  <= 1'b0;
      ck_p1  <= 1'b0;
      ck_p2  <= 1'b0;
      dat_p0 <= 1'b0;
      dat_p1 <= 1'b0;
      cs_p0  <= 1'b1;
      cs_p1  <= 1'b1;
      cs_p2  <= 1'b1;
    end else begin
      ck_p0  <= SPIck_ai;
      ck_p1  <= ck_p0;
      ck_p2  <= ck_p1;
      dat_p0 <= SPIdat_ai;
      dat_p1 <= dat_p0;
      cs_p0  <= SPIcs_n_ai;
      cs_p1  <= cs_p0;
      cs_p2  <= cs_p1;
    end
  end

  assign ck_rise = ck_p1 & ~ck_p2;
  assign cs_fall = ~cs_p1 & cs_p2;
  assign Busy_o  = ~cs_p1;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    addr_nxt    = addr;
    wrote_nxt   = wrote;
    err_nxt     = Err_o;
    done_nxt    = 1'b0;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = WrAddr_o;
    wr_data_nxt = WrData_o;

    if (cs_p1) begin
      // Frame closed: any SCK edge seen this cycle is dropped.
      state_nxt = IDLE;
      if (state == DATA) begin
        if (bit_cnt != '0) err_nxt = 1'b1;
        else if (wrote)    done_nxt = 1'b1;
      end else if (state == HDR && bit_cnt != '0) begin
        err_nxt = 1'b1;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state_nxt   = HDR;
            err_nxt     = 1'b0;
            bit_cnt_nxt = '0;
            wrote_nxt   = 1'b0;
          end
        end
        HDR: begin
          if (bit_cnt == HDR_BITS) begin
            bit_cnt_nxt = '0;
            if (shreg[HW-1]) begin
              addr_nxt  = shreg[AW-1:0];
              state_nxt = DATA;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IGNORE;
            end
          end else if (ck_rise) begin
            shreg_nxt   = {shreg[SW-2:0], dat_p1};
            bit_cnt_nxt = bit_cnt + CW'(1);
          end
        end
        DATA: begin
          // A full word is committed one cycle after its last bit lands.
          if (bit_cnt == WORD_BITS) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr;
            wr_data_nxt = shreg[IW-1:0];
            addr_nxt    = addr + AW'(1);
            bit_cnt_nxt = '0;
            wrote_nxt   = 1'b1;
          end else if (ck_rise) begin
            shreg_nxt   = {shreg[SW-2:0], dat_p1};
            bit_cnt_nxt = bit_cnt + CW'(1);
          end
        end
        IGNORE: begin
          state_nxt = IGNORE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p3: FSM state, datapath and registered outputs
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      addr     <= '0;
      wrote    <= 1'b0;
      Err_o    <= 1'b0;
      Done_o   <= 1'b0;
      WrEn_o   <= 1'b0;
      WrAddr_o <= '0;
      WrData_o <= '0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      addr     <= addr_nxt;
      wrote    <= wrote_nxt;
      Err_o    <= err_nxt;
      Done_o   <= done_nxt;
      WrEn_o   <= wr_en_nxt;
      WrAddr_o <= wr_addr_nxt;
      WrData_o <= wr_data_nxt;
    end
  end

endmodule
